// File: rtl/rs_station.sv
// rs_station: reservation station for the ALU path.
// Holds up to DEPTH issued instructions, snoops NUM_CDB result broadcast
// channels for pending operands, and dispatches one ready instruction per
// cycle through a registered valid/ready output stage.
// Optional build macro RS_AGE_ORDER_EN: oldest-first selection through a
// DEPTH x DEPTH age matrix; otherwise the lowest-index ready entry wins.
module rs_station #(
    parameter int DEPTH   = 16,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 7,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_imm,
    input  logic [31:0]                in_v1,
    input  logic [31:0]                in_v2,
    input  logic                       in_dep1,
    input  logic                       in_dep2,
    input  logic [ROB_W-1:0]           in_q1,
    input  logic [ROB_W-1:0]           in_q2,
    input  logic [ROB_W-1:0]           in_dest,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_id,
    input  logic [NUM_CDB*32-1:0]      cdb_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            out_op,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_imm,
    output logic [31:0]                out_v1,
    output logic [31:0]                out_v2,
    output logic [ROB_W-1:0]           out_dest,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entry storage (flops: every entry is compared against every channel each cycle)
    logic [DEPTH-1:0]             busy_reg, busy_next;
    logic [DEPTH-1:0]             dep1_reg, dep1_next;
    logic [DEPTH-1:0]             dep2_reg, dep2_next;
    logic [DEPTH-1:0][ROB_W-1:0]  q1_reg, q1_next;
    logic [DEPTH-1:0][ROB_W-1:0]  q2_reg, q2_next;
    logic [DEPTH-1:0][ROB_W-1:0]  dest_reg, dest_next;
    logic [DEPTH-1:0][31:0]       v1_reg, v1_next;
    logic [DEPTH-1:0][31:0]       v2_reg, v2_next;
    logic [DEPTH-1:0][31:0]       pc_reg, pc_next;
    logic [DEPTH-1:0][31:0]       imm_reg, imm_next;
    logic [DEPTH-1:0][OP_W-1:0]   op_reg, op_next;

    // Dispatch register
    logic                         out_valid_reg, out_valid_next;
    logic [OP_W-1:0]              out_op_reg, out_op_next;
    logic [31:0]                  out_pc_reg, out_pc_next;
    logic [31:0]                  out_imm_reg, out_imm_next;
    logic [31:0]                  out_v1_reg, out_v1_next;
    logic [31:0]                  out_v2_reg, out_v2_next;
    logic [ROB_W-1:0]             out_dest_reg, out_dest_next;
    logic [CNT_W-1:0]             count_reg, count_next;

`ifdef RS_AGE_ORDER_EN
    // age_reg[i][j] set means entry j is older than entry i
    logic [DEPTH-1:0][DEPTH-1:0]  age_reg, age_next;
`endif

    logic [DEPTH-1:0]             ready_vec;
    logic [IDX_W-1:0]             free_idx;
    logic [IDX_W-1:0]             sel_idx;
    logic                         sel_any;
    logic                         accept;
    logic                         adv;
    logic [32:0]                  wake1 [DEPTH];
    logic [32:0]                  wake2 [DEPTH];
    logic [32:0]                  cap1;
    logic [32:0]                  cap2;

    // Broadcast lookup: {hit, value}; the lowest matching channel wins.
    // All channel signals are arguments so continuous assigns stay sensitive to them.
    function automatic logic [32:0] cdb_lookup(
        input logic [NUM_CDB-1:0]       valid,
        input logic [NUM_CDB*ROB_W-1:0] ids,
        input logic [NUM_CDB*32-1:0]    values,
        input logic [ROB_W-1:0]         q
    );
        logic [32:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (valid[c] && (ids[c*ROB_W +: ROB_W] == q)) begin
                res = {1'b1, values[c*32 +: 32]};
            end
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
        assign wake1[gi] = cdb_lookup(cdb_valid, cdb_rob_id, cdb_value, q1_reg[gi]);
        assign wake2[gi] = cdb_lookup(cdb_valid, cdb_rob_id, cdb_value, q2_reg[gi]);
    end

    assign cap1      = cdb_lookup(cdb_valid, cdb_rob_id, cdb_value, in_q1);
    assign cap2      = cdb_lookup(cdb_valid, cdb_rob_id, cdb_value, in_q2);
    assign ready_vec = busy_reg & ~dep1_reg & ~dep2_reg;
    assign in_ready  = (count_reg != CNT_W'(DEPTH));
    assign accept    = rdy && in_valid && in_ready && !flush;
    assign adv       = rdy && !flush && (!out_valid_reg || out_ready) && sel_any;

    // Lowest-index free slot, judged on registered busy bits only
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_reg[i]) free_idx = IDX_W'(i);
        end
    end

    // Pick the entry to dispatch among the ready ones
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef RS_AGE_ORDER_EN
            if (ready_vec[i] && ((age_reg[i] & ready_vec) == '0)) begin
`else
            if (ready_vec[i]) begin
`endif
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
        end
    end

`ifdef RS_AGE_ORDER_EN
    // New entry is younger than everything busy; nobody is younger than it yet
    always_comb begin
        age_next = age_reg;
        if (rdy) begin
            if (flush) begin
                age_next = '0;
            end else if (accept) begin
                for (int r = 0; r < DEPTH; r++) age_next[r][free_idx] = 1'b0;
                age_next[free_idx] = busy_reg;
            end
        end
    end

    // Age matrix register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) age_reg <= '0;
        else      age_reg <= age_next;
    end
`endif

    // Next state: wakeup, advance into the dispatch register, accept, count
    always_comb begin
        busy_next      = busy_reg;
        dep1_next      = dep1_reg;
        dep2_next      = dep2_reg;
        q1_next        = q1_reg;
        q2_next        = q2_reg;
        dest_next      = dest_reg;
        v1_next        = v1_reg;
        v2_next        = v2_reg;
        pc_next        = pc_reg;
        imm_next       = imm_reg;
        op_next        = op_reg;
        out_valid_next = out_valid_reg;
        out_op_next    = out_op_reg;
        out_pc_next    = out_pc_reg;
        out_imm_next   = out_imm_reg;
        out_v1_next    = out_v1_reg;
        out_v2_next    = out_v2_reg;
        out_dest_next  = out_dest_reg;
        count_next     = count_reg;
        if (rdy) begin
            if (flush) begin
                busy_next      = '0;
                out_valid_next = 1'b0;
                count_next     = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_reg[i] && dep1_reg[i] && wake1[i][32]) begin
                        dep1_next[i] = 1'b0;
                        v1_next[i]   = wake1[i][31:0];
                    end
                    if (busy_reg[i] && dep2_reg[i] && wake2[i][32]) begin
                        dep2_next[i] = 1'b0;
                        v2_next[i]   = wake2[i][31:0];
                    end
                end
                if (adv) begin
                    busy_next[sel_idx] = 1'b0;
                    out_valid_next     = 1'b1;
                    out_op_next        = op_reg[sel_idx];
                    out_pc_next        = pc_reg[sel_idx];
                    out_imm_next       = imm_reg[sel_idx];
                    out_v1_next        = v1_reg[sel_idx];
                    out_v2_next        = v2_reg[sel_idx];
                    out_dest_next      = dest_reg[sel_idx];
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                end
                if (accept) begin
                    busy_next[free_idx] = 1'b1;
                    op_next[free_idx]   = in_op;
                    pc_next[free_idx]   = in_pc;
                    imm_next[free_idx]  = in_imm;
                    dest_next[free_idx] = in_dest;
                    q1_next[free_idx]   = in_q1;
                    q2_next[free_idx]   = in_q2;
                    dep1_next[free_idx] = in_dep1 && !cap1[32];
                    dep2_next[free_idx] = in_dep2 && !cap2[32];
                    v1_next[free_idx]   = (in_dep1 && cap1[32]) ? cap1[31:0] : in_v1;
                    v2_next[free_idx]   = (in_dep2 && cap2[32]) ? cap2[31:0] : in_v2;
                end
                if (accept && !adv) begin
                    count_next = count_reg + CNT_W'(1);
                end else if (adv && !accept) begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg      <= '0;
            dep1_reg      <= '0;
            dep2_reg      <= '0;
            q1_reg        <= '0;
            q2_reg        <= '0;
            dest_reg      <= '0;
            v1_reg        <= '0;
            v2_reg        <= '0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            op_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_op_reg    <= '0;
            out_pc_reg    <= '0;
            out_imm_reg   <= '0;
            out_v1_reg    <= '0;
            out_v2_reg    <= '0;
            out_dest_reg  <= '0;
            count_reg     <= '0;
        end else begin
            busy_reg      <= busy_next;
            dep1_reg      <= dep1_next;
            dep2_reg      <= dep2_next;
            q1_reg        <= q1_next;
            q2_reg        <= q2_next;
            dest_reg      <= dest_next;
            v1_reg        <= v1_next;
            v2_reg        <= v2_next;
            pc_reg        <= pc_next;
            imm_reg       <= imm_next;
            op_reg        <= op_next;
            out_valid_reg <= out_valid_next;
            out_op_reg    <= out_op_next;
            out_pc_reg    <= out_pc_next;
            out_imm_reg   <= out_imm_next;
            out_v1_reg    <= out_v1_next;
            out_v2_reg    <= out_v2_next;
            out_dest_reg  <= out_dest_next;
            count_reg     <= count_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_op    = out_op_reg;
    assign out_pc    = out_pc_reg;
    assign out_imm   = out_imm_reg;
    assign out_v1    = out_v1_reg;
    assign out_v2    = out_v2_reg;
    assign out_dest  = out_dest_reg;
    assign count     = count_reg;

endmodule
